decode_stage: RTL
=================

// Module: decode_stage
// PURPOSE
//  Registered, handshaked RV32I/E decode stage between fetch and execute. Accepts one
//  instruction per valid/ready transfer and emits one or two micro-ops on a registered
//  output interface. An internal micro-cycle counter sequences JAL/JALR/BRANCH (2 uops).
//  Register count and an optional RV32M decode are configurable. Supports flush.
// PARAMETERS
//  XLEN          32   data/address width; immediates sign-extended to XLEN
//  GP_REG_COUNT  32   16 (RV32E) or 32; any rs1/rs2/rd index >= count -> illegal
//  RA_W          $clog2(GP_REG_COUNT)  register-address width (derived, localparam)
// PORTS
//  clk               in   1       clock, rising edge
//  rst               in   1       synchronous reset, active-high
//  in_valid_i        in   1       fetch offers instr_i/instr_addr_i
//  in_ready_o        out  1       stage accepts this cycle
//  instr_i           in   32      instruction word
//  instr_addr_i      in   XLEN    instruction PC
//  flush_i           in   1       discard held instruction and pending uops
//  out_valid_o       out  1       uop fields below are valid
//  out_ready_i       in   1       execute consumes current uop
//  out_last_o        out  1       current uop is the final uop of its instruction
//  out_ucycle_o      out  1       uop index (0/1)
//  pc_o              out  XLEN    PC of the instruction
//  rs1_addr_o/rs2_addr_o/rd_addr_o out RA_W  register indices
//  rf_we_o, rf_write_sel_o  out 1 each  RF write enable / source (RF_WRITE_*)
//  alu_op_o          out  ALU_OP_WIDTH  ALU_* encoding
//  operand_a_sel_o/operand_b_sel_o out 2 each  ALU_OP_SEL_*
//  lsu_r_en_o, lsu_w_en_o, lsu_sign_extend_o out 1 each; lsu_data_type_o out 2 (DATA_*)
//  imm_o             out  XLEN    selected immediate
//  compressed_o, jump_o, branch_o, illegal_o  out 1 each  instruction class flags
//  md_en_o, md_op_o  out  1, 3    RV32M request / funct3 (only with MULDIV_EN)
// BEHAVIOUR
//  - Encodings from riscv_defines.sv. All outputs registered; all update only on a transfer.
//  - Reset: out_valid_o=0, every field output 0, ucycle=0, state EMPTY; in_ready_o=0 while rst.
//  - FSM: EMPTY -> UOP0 on input accept; UOP0 -> UOP1 on out transfer if !last;
//    UOPx -> UOP0 (new instr) on out transfer with last and input accept; -> EMPTY otherwise.
//  - in_ready_o = !flush_i && (state==EMPTY || (out_ready_i && out_last_o)); combinational.
//    Back-to-back 1-uop instructions sustain 1 instr/cycle. Input latency: 1 cycle.
//  - out_valid_o && !out_ready_i: all outputs held stable (no change, no recompute).
//  - Single uop: OP, OP-IMM, LUI, AUIPC, LOAD, STORE, SYSTEM, FENCE, illegal.
//  - JAL/JALR uop0: a=PC, b=IMM, imm=2/4 (compressed), ADD, rf_we=1.
//    uop1: rf_we=0; JAL a=PC imm=UJ; JALR a=RF1 imm=I.
//  - BRANCH uop0: a=RF1, b=RF2, compare op from funct3. uop1: a=PC, b=IMM, imm=SB, ADD.
//  - LUI: ALU_PASS, a=IMM, imm=U, rf_we=1. Shifts: imm=shamt (rs2 field, zero-ext).
//  - rd==0: rf_we_o forced 0. compressed_o = instr_i[1:0]!=2'b11.
//  - Illegal (bad opcode/funct3/funct7, reg index >= GP_REG_COUNT): one uop, illegal_o=1,
//    rf_we/lsu enables/jump/branch/md_en = 0, last=1.
//  - flush_i: next cycle out_valid_o=0, state EMPTY, ucycle=0; pending uop1 never issued;
//    no input accepted that cycle. flush and out transfer same cycle: flush wins.
//  - rst mid-instruction: identical to reset; no partial uop emitted.
// CONFIGURATION
//  - BURV_MULDIV_EN defined: OP with funct7=0x01 -> single uop, md_en_o=1, md_op_o=funct3,
//    rf_we_o=1 (unless rd==0), alu_op_o=ALU_AND.
//  - Undefined: md_en_o/md_op_o tied 0; funct7=0x01 in OP decodes illegal.
// TESTING
//  - ADDI x1,x2,5 (0x00510093) -> next cycle valid, ALU_ADD, b=IMM, imm=5, rd=1, rf_we=1, last=1.
//  - JAL x1,+8 (0x008000EF) @0x100 -> uop0 imm=4 a=PC rf_we=1 last=0; uop1 imm=8 rf_we=0
//    last=1; in_ready_o=0 during uop0.
//  - out_ready_i=0 for 3 cycles on any uop -> all outputs stable, in_ready_o=0; stream of
//    4 ADDIs with out_ready_i=1 -> 4 uops in 4 consecutive cycles.
//  - GP_REG_COUNT=16, ADD x17,x1,x2 (0x002088B3) -> illegal_o=1, rf_we_o=0.
//  - flush_i during JAL uop0 -> out_valid_o=0 next cycle, uop1 never appears, then accepts.
//  - MUL x3,x1,x2 (0x022081B3): with BURV_MULDIV_EN md_en=1 md_op=0 rd=3; without illegal_o=1.

Source files
------------

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// decode_stage : registered RV32I/E decode stage, 1-2 uops per instruction.
// Optional RV32M decode enabled by defining BURV_MULDIV_EN.   Rev 1.0
// ============================================================================
module decode_stage #(
  parameter int XLEN         = 32,
  parameter int GP_REG_COUNT = 32,
  localparam int RA_W         = $clog2(GP_REG_COUNT),
  localparam int ALU_OP_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [31:0]             instr_i,
  input  logic [XLEN-1:0]         instr_addr_i,
  input  logic                    flush_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic                    out_last_o,
  output logic                    out_ucycle_o,
  output logic [XLEN-1:0]         pc_o,
  output logic [RA_W-1:0]         rs1_addr_o,
  output logic [RA_W-1:0]         rs2_addr_o,
  output logic [RA_W-1:0]         rd_addr_o,
  output logic                    rf_we_o,
  output logic                    rf_write_sel_o,
  output logic [ALU_OP_WIDTH-1:0] alu_op_o,
  output logic [1:0]              operand_a_sel_o,
  output logic [1:0]              operand_b_sel_o,
  output logic                    lsu_r_en_o,
  output logic                    lsu_w_en_o,
  output logic                    lsu_sign_extend_o,
  output logic [1:0]              lsu_data_type_o,
  output logic [XLEN-1:0]         imm_o,
  output logic                    compressed_o,
  output logic                    jump_o,
  output logic                    branch_o,
  output logic                    illegal_o,
  output logic                    md_en_o,
  output logic [2:0]              md_op_o
);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = 5'd0,  ALU_SUB = 5'd1,  ALU_XOR = 5'd2,
    ALU_OR = 5'd3, ALU_AND = 5'd4, ALU_SLL = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7,
    ALU_SLT = 5'd8, ALU_SLTU = 5'd9, ALU_EQ = 5'd10, ALU_NE = 5'd11, ALU_LT = 5'd12,
    ALU_GE = 5'd13, ALU_LTU = 5'd14, ALU_GEU = 5'd15, ALU_PASS = 5'd16;
  localparam logic [1:0] ALU_OP_SEL_RF1 = 2'd0, ALU_OP_SEL_RF2 = 2'd1,
    ALU_OP_SEL_IMM = 2'd2, ALU_OP_SEL_PC = 2'd3;
  localparam logic RF_WRITE_ALU = 1'b0, RF_WRITE_LSU = 1'b1;
  localparam logic [1:0] DATA_WORD = 2'd2;
  localparam logic [4:0] OPC_LOAD = 5'b00000, OPC_MISC_MEM = 5'b00011, OPC_OP_IMM = 5'b00100,
    OPC_AUIPC = 5'b00101, OPC_STORE = 5'b01000, OPC_OP = 5'b01100, OPC_LUI = 5'b01101,
    OPC_BRANCH = 5'b11000, OPC_JALR = 5'b11001, OPC_JAL = 5'b11011, OPC_SYSTEM = 5'b11100;

  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_UOP0 = 2'd1, S_UOP1 = 2'd2} state_t;

  function automatic logic [ALU_OP_WIDTH-1:0] alu_arith(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    alu_arith = alt ? ALU_SUB : ALU_ADD;
      3'd1:    alu_arith = ALU_SLL;
      3'd2:    alu_arith = ALU_SLT;
      3'd3:    alu_arith = ALU_SLTU;
      3'd4:    alu_arith = ALU_XOR;
      3'd5:    alu_arith = alt ? ALU_SRA : ALU_SRL;
      3'd6:    alu_arith = ALU_OR;
      default: alu_arith = ALU_AND;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    sext = XLEN'($signed(v));
  endfunction

  state_t                  state_q;
  logic                    out_valid_q, out_last_q, ucycle_q;
  logic [31:0]             instr_q;
  logic [XLEN-1:0]         pc_q, opc_pc_q, imm_q;
  logic [RA_W-1:0]         rs1_q, rs2_q, rd_q;
  logic                    rf_we_q, wsel_q, lsu_r_q, lsu_w_q, sext_q, comp_q, jump_q, branch_q, ill_q;
  logic [ALU_OP_WIDTH-1:0] alu_q;
  logic [1:0]              a_sel_q, b_sel_q, dtype_q;

  logic                    in_accept, out_xfer, uc;
  logic [31:0]             ins;
  logic [2:0]              f3;
  logic [6:0]              f7;
  logic                    use_rs1, use_rs2, use_rd;
  logic                    rf_we_d, wsel_d, lsu_r_d, lsu_w_d, sext_d, jump_d, branch_d, ill_d, last_d;
  logic [ALU_OP_WIDTH-1:0] alu_d;
  logic [1:0]              a_sel_d, b_sel_d, dtype_d;
  logic [XLEN-1:0]         imm_d;
`ifdef BURV_MULDIV_EN
  logic                    md_en_d, md_en_q;
  logic [2:0]              md_op_q;
`endif

  assign in_ready_o = !rst && !flush_i && (state_q == S_EMPTY || (out_ready_i && out_last_q));
  assign in_accept  = in_valid_i && in_ready_o;
  assign out_xfer   = out_valid_q && out_ready_i;
  // uop1 is decoded from the held copy of the instruction, uop0 straight from the input
  assign uc  = !in_accept;
  assign ins = in_accept ? instr_i : instr_q;
  assign f3  = ins[14:12];
  assign f7  = ins[31:25];

  always_comb begin
    rf_we_d = 1'b0; wsel_d = RF_WRITE_ALU; alu_d = ALU_ADD;
    a_sel_d = ALU_OP_SEL_RF1; b_sel_d = ALU_OP_SEL_RF2;
    lsu_r_d = 1'b0; lsu_w_d = 1'b0; sext_d = 1'b0; dtype_d = DATA_WORD;
    imm_d = '0; jump_d = 1'b0; branch_d = 1'b0; ill_d = 1'b0;
    use_rs1 = 1'b0; use_rs2 = 1'b0; use_rd = 1'b0;
`ifdef BURV_MULDIV_EN
    md_en_d = 1'b0;
`endif
    case (ins[6:2])
      OPC_OP: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; rf_we_d = 1'b1;
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) alu_d = alu_arith(f3, f7[5]);
`ifdef BURV_MULDIV_EN
        else if (f7 == 7'h01) begin md_en_d = 1'b1; alu_d = ALU_AND; end
`endif
        else ill_d = 1'b1;
      end
      OPC_OP_IMM: begin
        use_rs1 = 1'b1; use_rd = 1'b1; rf_we_d = 1'b1; b_sel_d = ALU_OP_SEL_IMM;
        alu_d = alu_arith(f3, f3 == 3'd5 && f7[5]);
        if (f3 == 3'd1 || f3 == 3'd5) begin
          imm_d = XLEN'(ins[24:20]);
          ill_d = !(f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20));
        end else imm_d = sext({{20{ins[31]}}, ins[31:20]});
      end
      OPC_LUI: begin
        use_rd = 1'b1; rf_we_d = 1'b1; alu_d = ALU_PASS;
        a_sel_d = ALU_OP_SEL_IMM; b_sel_d = ALU_OP_SEL_IMM; imm_d = sext({ins[31:12], 12'b0});
      end
      OPC_AUIPC: begin
        use_rd = 1'b1; rf_we_d = 1'b1;
        a_sel_d = ALU_OP_SEL_PC; b_sel_d = ALU_OP_SEL_IMM; imm_d = sext({ins[31:12], 12'b0});
      end
      OPC_LOAD: begin
        use_rs1 = 1'b1; use_rd = 1'b1; rf_we_d = 1'b1; wsel_d = RF_WRITE_LSU; lsu_r_d = 1'b1;
        b_sel_d = ALU_OP_SEL_IMM; imm_d = sext({{20{ins[31]}}, ins[31:20]});
        sext_d = !f3[2]; dtype_d = f3[1:0];
        ill_d = (f3[1:0] == 2'b11) || (f3[2] && f3[1]);
      end
      OPC_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; lsu_w_d = 1'b1; b_sel_d = ALU_OP_SEL_IMM;
        imm_d = sext({{20{ins[31]}}, ins[31:25], ins[11:7]}); dtype_d = f3[1:0];
        ill_d = (f3 > 3'd2);
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; branch_d = 1'b1;
        imm_d = sext({{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
        ill_d = (f3 == 3'd2 || f3 == 3'd3);
        if (uc) begin
          a_sel_d = ALU_OP_SEL_PC; b_sel_d = ALU_OP_SEL_IMM;
        end else begin
          case (f3)
            3'd0: alu_d = ALU_EQ;   3'd1: alu_d = ALU_NE;
            3'd4: alu_d = ALU_LT;   3'd5: alu_d = ALU_GE;
            3'd6: alu_d = ALU_LTU;  default: alu_d = ALU_GEU;
          endcase
        end
      end
      OPC_JAL, OPC_JALR: begin
        use_rd = 1'b1; use_rs1 = ins[3] == 1'b0; jump_d = 1'b1; b_sel_d = ALU_OP_SEL_IMM;
        ill_d = ins[3] == 1'b0 && f3 != 3'd0;
        if (!uc) begin
          // uop0 computes the link address PC + instruction length
          a_sel_d = ALU_OP_SEL_PC; rf_we_d = 1'b1;
          imm_d = (ins[1:0] != 2'b11) ? XLEN'(2) : XLEN'(4);
        end else if (ins[3]) begin
          a_sel_d = ALU_OP_SEL_PC;
          imm_d = sext({{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
        end else begin
          a_sel_d = ALU_OP_SEL_RF1; imm_d = sext({{20{ins[31]}}, ins[31:20]});
        end
      end
      OPC_SYSTEM, OPC_MISC_MEM: ;
      default: ill_d = 1'b1;
    endcase
    if ((use_rs1 && 32'(ins[19:15]) >= GP_REG_COUNT) || (use_rs2 && 32'(ins[24:20]) >= GP_REG_COUNT)
        || (use_rd && 32'(ins[11:7]) >= GP_REG_COUNT)) ill_d = 1'b1;
    if (ins[11:7] == 5'd0) rf_we_d = 1'b0;
    if (ill_d) begin
      rf_we_d = 1'b0; lsu_r_d = 1'b0; lsu_w_d = 1'b0; jump_d = 1'b0; branch_d = 1'b0;
`ifdef BURV_MULDIV_EN
      md_en_d = 1'b0;
`endif
    end
    last_d = uc || !(jump_d || branch_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY; out_valid_q <= 1'b0; out_last_q <= 1'b0; ucycle_q <= 1'b0;
      instr_q <= '0; pc_q <= '0; opc_pc_q <= '0; imm_q <= '0;
      rs1_q <= '0; rs2_q <= '0; rd_q <= '0; rf_we_q <= 1'b0; wsel_q <= 1'b0;
      alu_q <= '0; a_sel_q <= '0; b_sel_q <= '0; lsu_r_q <= 1'b0; lsu_w_q <= 1'b0;
      sext_q <= 1'b0; dtype_q <= '0; comp_q <= 1'b0; jump_q <= 1'b0; branch_q <= 1'b0; ill_q <= 1'b0;
`ifdef BURV_MULDIV_EN
      md_en_q <= 1'b0; md_op_q <= '0;
`endif
    end else if (flush_i) begin
      state_q <= S_EMPTY; out_valid_q <= 1'b0; ucycle_q <= 1'b0;
    end else if (in_accept || (out_xfer && !out_last_q)) begin
      state_q <= in_accept ? S_UOP0 : S_UOP1;
      out_valid_q <= 1'b1; out_last_q <= last_d; ucycle_q <= uc;
      if (in_accept) begin
        instr_q <= instr_i; pc_q <= instr_addr_i; opc_pc_q <= instr_addr_i;
      end
      rs1_q <= ins[15 +: RA_W]; rs2_q <= ins[20 +: RA_W]; rd_q <= ins[7 +: RA_W];
      rf_we_q <= rf_we_d; wsel_q <= wsel_d; alu_q <= alu_d; a_sel_q <= a_sel_d; b_sel_q <= b_sel_d;
      lsu_r_q <= lsu_r_d; lsu_w_q <= lsu_w_d; sext_q <= sext_d; dtype_q <= dtype_d; imm_q <= imm_d;
      comp_q <= ins[1:0] != 2'b11; jump_q <= jump_d; branch_q <= branch_d; ill_q <= ill_d;
`ifdef BURV_MULDIV_EN
      md_en_q <= md_en_d; md_op_q <= f3;
`endif
    end else if (out_xfer) begin
      state_q <= S_EMPTY; out_valid_q <= 1'b0; ucycle_q <= 1'b0;
    end
  end

  assign out_valid_o = out_valid_q;       assign out_last_o = out_last_q;
  assign out_ucycle_o = ucycle_q;         assign pc_o = opc_pc_q;
  assign rs1_addr_o = rs1_q;              assign rs2_addr_o = rs2_q;
  assign rd_addr_o = rd_q;                assign rf_we_o = rf_we_q;
  assign rf_write_sel_o = wsel_q;         assign alu_op_o = alu_q;
  assign operand_a_sel_o = a_sel_q;       assign operand_b_sel_o = b_sel_q;
  assign lsu_r_en_o = lsu_r_q;            assign lsu_w_en_o = lsu_w_q;
  assign lsu_sign_extend_o = sext_q;      assign lsu_data_type_o = dtype_q;
  assign imm_o = imm_q;                   assign compressed_o = comp_q;
  assign jump_o = jump_q;                 assign branch_o = branch_q;
  assign illegal_o = ill_q;
`ifdef BURV_MULDIV_EN
  assign md_en_o = md_en_q;               assign md_op_o = md_op_q;
`else
  assign md_en_o = 1'b0;                  assign md_op_o = 3'b000;
`endif
endmodule
`default_nettype wire
